// File: rtl/debug_probe_bank.sv
// Debug probe bank: samples CH_NUM signed probes and pages them onto PAGE_SIZE sign-extended fields.
// Optional DEBUG_PROBE_MINMAX_EN adds per-channel min/max trackers, clear handling and the LIVE/MIN/MAX mode FSM.
module debug_probe_bank #(
    parameter  int CH_NUM    = 8,
    parameter  int IN_WIDTH  = 17,
    parameter  int SEQ_LEN   = 20,
    parameter  int PAGE_SIZE = 6,
    localparam int NPAGES    = (CH_NUM + PAGE_SIZE - 1) / PAGE_SIZE,
    localparam int PW        = $clog2(NPAGES) + 1
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         sample_tick,
    input  logic [CH_NUM*IN_WIDTH-1:0]   probe_in,
    input  logic                         freeze_btn,
    input  logic                         page_btn,
    input  logic                         mode_btn,
    input  logic                         clear,
    output logic [PAGE_SIZE*SEQ_LEN-1:0] bcd_seq,
    output logic [PW-1:0]                page_idx,
    output logic [1:0]                   mode,
    output logic                         frozen
);

    localparam logic [1:0] MODE_LIVE = 2'd0;
    localparam logic [1:0] MODE_MIN  = 2'd1;
    localparam logic [1:0] MODE_MAX  = 2'd2;

    genvar gi;

    logic                         r_armed;
    logic                         r_freeze_d;
    logic                         r_page_d;
    logic                         r_frozen;
    logic [PW-1:0]                r_page;
    logic signed [IN_WIDTH-1:0]   r_cap [CH_NUM];
    logic [PAGE_SIZE*SEQ_LEN-1:0] r_bcd;
    logic [PAGE_SIZE*SEQ_LEN-1:0] w_bcd_next;
    logic signed [IN_WIDTH-1:0]   w_smp [CH_NUM];
    logic                         w_freeze_edge;
    logic                         w_page_edge;
    logic                         w_accept;
    logic [1:0]                   w_mode;

    // r_armed masks the first clock after reset so a button already held high is not seen as an edge.
    assign w_freeze_edge = r_armed & freeze_btn & ~r_freeze_d;
    assign w_page_edge   = r_armed & page_btn   & ~r_page_d;
    assign w_accept      = sample_tick & ~r_frozen;

    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_smp
            assign w_smp[gi] = probe_in[gi*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_armed    <= 1'b0;
            r_freeze_d <= 1'b0;
            r_page_d   <= 1'b0;
            r_frozen   <= 1'b0;
            r_page     <= '0;
            r_bcd      <= '0;
            for (int c = 0; c < CH_NUM; c++) r_cap[c] <= '0;
        end else begin
            r_armed    <= 1'b1;
            r_freeze_d <= freeze_btn;
            r_page_d   <= page_btn;
            r_bcd      <= w_bcd_next;
            if (w_freeze_edge) r_frozen <= ~r_frozen;
            if (w_page_edge) r_page <= (r_page == PW'(NPAGES - 1)) ? '0 : r_page + 1'b1;
            for (int c = 0; c < CH_NUM; c++)
                if (w_accept) r_cap[c] <= w_smp[c];
        end
    end

`ifdef DEBUG_PROBE_MINMAX_EN
    logic                       r_mode_d;
    logic                       r_first;
    logic                       r_clr_pend;
    logic [1:0]                 r_mode;
    logic [1:0]                 w_mode_next;
    logic                       w_mode_edge;
    logic                       w_reload;
    logic signed [IN_WIDTH-1:0] r_min [CH_NUM];
    logic signed [IN_WIDTH-1:0] r_max [CH_NUM];

    assign w_mode_edge = r_armed & mode_btn & ~r_mode_d;
    // A clear seen in the same cycle as an accepted sample also forces a reload.
    assign w_reload    = r_first | r_clr_pend | clear;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode_d   <= 1'b0;
            r_first    <= 1'b1;
            r_clr_pend <= 1'b0;
            for (int c = 0; c < CH_NUM; c++) begin
                r_min[c] <= '0;
                r_max[c] <= '0;
            end
        end else begin
            r_mode_d <= mode_btn;
            if (w_accept) begin
                r_first    <= 1'b0;
                r_clr_pend <= 1'b0;
            end else if (clear) begin
                r_clr_pend <= 1'b1;
            end
            for (int c = 0; c < CH_NUM; c++) begin
                if (w_accept && (w_reload || w_smp[c] < r_min[c])) r_min[c] <= w_smp[c];
                if (w_accept && (w_reload || w_smp[c] > r_max[c])) r_max[c] <= w_smp[c];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_mode <= MODE_LIVE;
        else            r_mode <= w_mode_next;
    end

    always_comb begin
        w_mode_next = r_mode;
        if (w_mode_edge) begin
            case (r_mode)
                MODE_LIVE: w_mode_next = MODE_MIN;
                MODE_MIN:  w_mode_next = MODE_MAX;
                default:   w_mode_next = MODE_LIVE;
            endcase
        end
    end

    always_comb begin
        case (r_mode)
            MODE_MIN: w_mode = MODE_MIN;
            MODE_MAX: w_mode = MODE_MAX;
            default:  w_mode = MODE_LIVE;
        endcase
    end
`else
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, mode_btn, clear};
    assign w_mode      = MODE_LIVE;
`endif

    // Slots past the last channel stay zero because no channel index matches them.
    generate
        for (gi = 0; gi < PAGE_SIZE; gi++) begin : g_slot
            logic signed [IN_WIDTH-1:0] w_sel;
            always_comb begin
                w_sel = '0;
                for (int c = 0; c < CH_NUM; c++) begin
                    if (int'(r_page) * PAGE_SIZE + gi == c) begin
`ifdef DEBUG_PROBE_MINMAX_EN
                        case (w_mode)
                            MODE_MIN: w_sel = r_min[c];
                            MODE_MAX: w_sel = r_max[c];
                            default:  w_sel = r_cap[c];
                        endcase
`else
                        w_sel = r_cap[c];
`endif
                    end
                end
            end
            assign w_bcd_next[gi*SEQ_LEN +: SEQ_LEN] = SEQ_LEN'(w_sel);
        end
    endgenerate

    assign bcd_seq  = r_bcd;
    assign page_idx = r_page;
    assign mode     = w_mode;
    assign frozen   = r_frozen;

endmodule

// File: tb/tb_debug_probe_bank.sv
// Testbench for debug_probe_bank: directed scenarios plus randomized traffic against a behavioural model.
module tb_debug_probe_bank;

    localparam int CH = 8;
    localparam int IW = 17;
    localparam int SL = 20;
    localparam int PS = 6;
    localparam int NP = 2;
    localparam int PW = 2;

    logic             sys_clk     = 1'b0;
    logic             sys_rst_n   = 1'b1;
    logic             sample_tick = 1'b0;
    logic             freeze_btn  = 1'b0;
    logic             page_btn    = 1'b0;
    logic             mode_btn    = 1'b0;
    logic             clear       = 1'b0;
    logic [CH*IW-1:0] probe_in    = '0;
    wire  [PS*SL-1:0] bcd_seq;
    wire  [PW-1:0]    page_idx;
    wire  [1:0]       mode;
    wire              frozen;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 sys_clk = ~sys_clk;

    debug_probe_bank #(
        .CH_NUM   (CH),
        .IN_WIDTH (IW),
        .SEQ_LEN  (SL),
        .PAGE_SIZE(PS)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sample_tick(sample_tick),
        .probe_in   (probe_in),
        .freeze_btn (freeze_btn),
        .page_btn   (page_btn),
        .mode_btn   (mode_btn),
        .clear      (clear),
        .bcd_seq    (bcd_seq),
        .page_idx   (page_idx),
        .mode       (mode),
        .frozen     (frozen)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integers per channel, display view computed from the current page/mode.
    int               m_cap [CH];
    int               m_min [CH];
    int               m_max [CH];
    bit               m_first  = 1'b1;
    bit               m_pend   = 1'b0;
    bit               m_frozen = 1'b0;
    bit               m_seen   = 1'b0;
    bit               m_pf     = 1'b0;
    bit               m_pp     = 1'b0;
    bit               m_pm     = 1'b0;
    int               m_page   = 0;
    int               m_mode   = 0;
    logic [PS*SL-1:0] m_bcd    = '0;

    function automatic logic [PS*SL-1:0] view();
        logic [PS*SL-1:0] r;
        int               ch;
        int               v;
        logic [31:0]      vb;
        r = '0;
        for (int s = 0; s < PS; s++) begin
            ch = m_page * PS + s;
            v  = 0;
            if (ch < CH) begin
                if (m_mode == 1)      v = m_min[ch];
                else if (m_mode == 2) v = m_max[ch];
                else                  v = m_cap[ch];
            end
            vb = v;
            r[s*SL +: SL] = vb[SL-1:0];
        end
        return r;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        logic [PS*SL-1:0]  nb;
        bit                fe, pe, me, rl;
        logic signed [IW-1:0] sv;
        int                s;
        if (!sys_rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_cap[c] = 0; m_min[c] = 0; m_max[c] = 0;
            end
            m_first = 1'b1; m_pend = 1'b0; m_frozen = 1'b0; m_seen = 1'b0;
            m_pf = 1'b0; m_pp = 1'b0; m_pm = 1'b0;
            m_page = 0; m_mode = 0; m_bcd = '0;
        end else begin
            nb = view();
            fe = m_seen && freeze_btn && !m_pf;
            pe = m_seen && page_btn && !m_pp;
            me = m_seen && mode_btn && !m_pm;
            if (sample_tick && !m_frozen) begin
                rl = m_first || m_pend || clear;
                for (int c = 0; c < CH; c++) begin
                    sv = probe_in[c*IW +: IW];
                    s  = sv;
                    m_cap[c] = s;
`ifdef DEBUG_PROBE_MINMAX_EN
                    if (rl || s < m_min[c]) m_min[c] = s;
                    if (rl || s > m_max[c]) m_max[c] = s;
`endif
                end
                m_first = 1'b0;
                m_pend  = 1'b0;
            end else if (clear) begin
                m_pend = 1'b1;
            end
            if (fe) m_frozen = !m_frozen;
            if (pe) m_page = (m_page + 1) % NP;
`ifdef DEBUG_PROBE_MINMAX_EN
            if (me) m_mode = (m_mode + 1) % 3;
`endif
            m_pf = freeze_btn; m_pp = page_btn; m_pm = mode_btn;
            m_seen = 1'b1;
            m_bcd  = nb;
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("bcd_seq", bcd_seq, m_bcd);
            chk("page_idx", page_idx, m_page[PW-1:0]);
            chk("mode", mode, m_mode[1:0]);
            chk("frozen", frozen, m_frozen);
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic press(input int which, input int hold);
        case (which)
            0: freeze_btn = 1'b1;
            1: page_btn   = 1'b1;
            default: mode_btn = 1'b1;
        endcase
        repeat (hold) step();
        freeze_btn = 1'b0; page_btn = 1'b0; mode_btn = 1'b0;
        repeat (2) step();
    endtask

    task automatic sample();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        #1 sys_rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        chk("rst_bcd", bcd_seq, '0);
        chk("rst_page", page_idx, '0);
        chk("rst_mode", mode, '0);
        chk("rst_frozen", frozen, 1'b0);
        step();

        // ch0 = -5: one-cycle latency after the sampling edge
        probe_in[0 +: IW] = 17'h1FFFB;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("slot0_before", bcd_seq[0 +: SL], '0);
        step();
        chk("slot0_m5", bcd_seq[0 +: SL], 20'hFFFFB);
        step();

        // freeze holds the capture
        press(0, 1);
        chk("frozen_on", frozen, 1'b1);
        probe_in[1*IW +: IW] = 17'd100;
        sample();
        chk("slot1_held", bcd_seq[1*SL +: SL], '0);
        press(0, 1);
        chk("frozen_off", frozen, 1'b0);
        sample();
        chk("slot1_100", bcd_seq[1*SL +: SL], 20'd100);

        // page sequence with long button holds
        press(1, 10);
        chk("page_1st", page_idx, 2'd1);
        chk("page1_empty_slots", bcd_seq[2*SL +: 4*SL], '0);
        press(1, 10);
        chk("page_2nd", page_idx, 2'd0);
        press(1, 10);
        chk("page_3rd", page_idx, 2'd1);
        press(1, 3);

`ifdef DEBUG_PROBE_MINMAX_EN
        probe_in[2*IW +: IW] = 17'd7;          sample();
        probe_in[2*IW +: IW] = 17'h1FFFD;      sample();
        probe_in[2*IW +: IW] = 17'd12;         sample();
        press(2, 3);
        chk("mode_min", mode, 2'd1);
        chk("min_slot2", bcd_seq[2*SL +: SL], 20'hFFFFD);
        press(2, 3);
        chk("mode_max", mode, 2'd2);
        chk("max_slot2", bcd_seq[2*SL +: SL], 20'd12);
        clear = 1'b1; step(); clear = 1'b0; step();
        probe_in[2*IW +: IW] = 17'd5;          sample();
        chk("max_after_clear", bcd_seq[2*SL +: SL], 20'd5);
        press(2, 3);
        press(2, 3);
        chk("mode_wrap_min", mode, 2'd1);
        chk("min_after_clear", bcd_seq[2*SL +: SL], 20'd5);
        press(2, 3);
        chk("mode_max_again", mode, 2'd2);
`else
        press(2, 3);
        chk("mode_stuck_live", mode, 2'd0);
        chk("live_slot0", bcd_seq[0 +: SL], 20'hFFFFB);
        press(2, 3);
        chk("mode_stuck_live2", mode, 2'd0);
`endif
        press(1, 3);
        chk("page_before_rst", page_idx, 2'd1);

        // asynchronous reset mid-sample
        for (int c = 0; c < CH; c++) probe_in[c*IW +: IW] = IW'($urandom);
        sample_tick = 1'b1;
        #1 sys_rst_n = 1'b0;
        #1;
        chk("async_bcd", bcd_seq, '0);
        chk("async_page", page_idx, '0);
        chk("async_mode", mode, '0);
        chk("async_frozen", frozen, 1'b0);
        step();
        sample_tick = 1'b0;
        page_btn = 1'b1;
        step();
        sys_rst_n = 1'b1;
        repeat (3) step();
        chk("no_edge_after_rst", page_idx, '0);
        page_btn = 1'b0;
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 1) == 0) probe_in[c*IW +: IW] = IW'($urandom);
                else probe_in[c*IW +: IW] = IW'($urandom_range(0, 40)) - IW'(20);
            end
            sample_tick = ($urandom_range(0, 2) == 0);
            clear       = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) freeze_btn = ~freeze_btn;
            if ($urandom_range(0, 4) == 0) page_btn   = ~page_btn;
            if ($urandom_range(0, 4) == 0) mode_btn   = ~mode_btn;
            if (i == 1500) sys_rst_n = 1'b0;
            if (i == 1503) sys_rst_n = 1'b1;
            step();
        end
        sample_tick = 1'b0; clear = 1'b0;
        repeat (3) step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
